fft_result_capture: RTL and testbench

AXI-Stream slave that receives one FFT result frame from the FFT master port (m00_axis_*) and stores it in an internal buffer indexed by arrival order. It checks frame length against the tlast position and byte strobes. Once the frame is captured, it holds the contents for random-access readout by the host/processor side. It is the receiving end of the FFT output stream: it provides backpressure through tready and is re-armed per frame.

---
 rtl/fft_result_capture.sv | 181 ++++++++++++++++++
 tb/tb_fft_result_capture.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_result_capture.sv
`default_nettype none
// ============================================================================
// Module   : fft_result_capture
// Brief    : AXI-Stream slave that captures one FFT result frame into an
//            internal buffer (indexed by arrival order), checks the frame
//            length against tlast and the byte strobes, then holds the frame
//            for random-access readout until it is re-armed.
// Revision : 1.0 - initial release
// ============================================================================
module fft_result_capture #(
    parameter int WIDTH      = 64,
    parameter int ADDR_WIDTH = 10,
    parameter int FRAME_LEN  = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  s00_axis_tready,
    input  logic [WIDTH-1:0]      s00_axis_tdata,
    input  logic [WIDTH/8-1:0]    s00_axis_tstrb,
    input  logic                  s00_axis_tlast,
    input  logic                  s00_axis_tvalid,
    input  logic                  arm,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  frame_done,
    output logic                  err_short,
    output logic                  err_long,
    output logic                  err_strb,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic                  busy
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_capture = 2'd1;
    localparam logic [1:0] c_st_drain   = 2'd2;
    localparam logic [1:0] c_st_hold    = 2'd3;

    // Index of the final word of a correctly sized frame
    localparam logic [ADDR_WIDTH:0]  c_last_idx  = (ADDR_WIDTH+1)'(FRAME_LEN-1);
    localparam logic [ADDR_WIDTH:0]  c_count_one = (ADDR_WIDTH+1)'(1);
    localparam logic [WIDTH/8-1:0]   c_strb_full = '1;

    // ------------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------------
    logic [1:0]            r_state;
    logic                  r_tready;
    logic                  r_busy;
    logic                  r_frame_done;
    logic                  r_err_short;
    logic                  r_err_long;
    logic                  r_err_strb;
    logic [ADDR_WIDTH:0]   r_count;
    logic [WIDTH-1:0]      r_rd_data;
    logic [WIDTH-1:0]      r_mem [0:FRAME_LEN-1];

    logic                  w_hs;
    logic                  w_wr_en;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic                  w_at_last_idx;
    logic                  w_strb_bad;

    // A transfer happens whenever the master offers data while we are ready
    assign w_hs          = s00_axis_tvalid && r_tready;

    // Only CAPTURE stores words; DRAIN discards them. Reset suppresses any
    // write so an aborted frame never touches the buffer at the reset edge.
    assign w_wr_en       = w_hs && (r_state == c_st_capture) && rst;

    // Words land at their arrival index; the count never exceeds
    // FRAME_LEN-1 while in CAPTURE, so the low bits are the full address.
    assign w_wr_addr     = r_count[ADDR_WIDTH-1:0];

    assign w_at_last_idx = (r_count == c_last_idx);
    assign w_strb_bad    = (s00_axis_tstrb != c_strb_full);

    // ------------------------------------------------------------------------
    // Control FSM: frame sequencing, word counting and status flags
    // ------------------------------------------------------------------------
    // Tracks the capture life cycle and keeps every status output registered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= c_st_idle;
            r_tready     <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_err_short  <= 1'b0;
            r_err_long   <= 1'b0;
            r_err_strb   <= 1'b0;
            r_count      <= '0;
        end else begin
            case (r_state)
                // IDLE and HOLD behave identically on arm: start a fresh frame
                c_st_idle, c_st_hold: begin
                    if (arm) begin
                        r_state      <= c_st_capture;
                        r_tready     <= 1'b1;
                        r_busy       <= 1'b1;
                        r_frame_done <= 1'b0;
                        r_err_short  <= 1'b0;
                        r_err_long   <= 1'b0;
                        r_err_strb   <= 1'b0;
                        r_count      <= '0;
                    end
                end

                c_st_capture: begin
                    if (w_hs) begin
                        r_count <= r_count + c_count_one;
                        if (w_strb_bad) begin
                            r_err_strb <= 1'b1;
                        end
                        if (s00_axis_tlast) begin
                            // Frame ends here; short unless this is the last slot
                            r_state      <= c_st_hold;
                            r_tready     <= 1'b0;
                            r_busy       <= 1'b0;
                            r_frame_done <= 1'b1;
                            r_err_short  <= !w_at_last_idx;
                        end else if (w_at_last_idx) begin
                            // Buffer full without tlast: swallow the rest
                            r_state    <= c_st_drain;
                            r_err_long <= 1'b1;
                        end
                    end
                end

                c_st_drain: begin
                    if (w_hs && s00_axis_tlast) begin
                        r_state      <= c_st_hold;
                        r_tready     <= 1'b0;
                        r_busy       <= 1'b0;
                        r_frame_done <= 1'b1;
                    end
                end

                default: begin
                    r_state  <= c_st_idle;
                    r_tready <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Frame buffer
    // ------------------------------------------------------------------------
    // Stores accepted words; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= s00_axis_tdata;
        end
    end

    // Registered readout; a same-address write in this cycle yields old data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign s00_axis_tready = r_tready;
    assign busy            = r_busy;
    assign frame_done      = r_frame_done;
    assign err_short       = r_err_short;
    assign err_long        = r_err_long;
    assign err_strb        = r_err_strb;
    assign word_count      = r_count;
    assign rd_data         = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_fft_result_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_result_capture
// Brief    : Self-checking bench for fft_result_capture. A frame-level model
//            predicts every output each cycle; directed literal checks pin it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft_result_capture;

    localparam int WIDTH = 64;
    localparam int AW    = 10;
    localparam int FL    = 1024;

    logic              clk = 1'b0;
    logic              rst;
    logic              s00_axis_tready;
    logic [WIDTH-1:0]  s00_axis_tdata;
    logic [7:0]        s00_axis_tstrb;
    logic              s00_axis_tlast;
    logic              s00_axis_tvalid;
    logic              arm;
    logic [AW-1:0]     rd_addr;
    logic [WIDTH-1:0]  rd_data;
    logic              frame_done;
    logic              err_short;
    logic              err_long;
    logic              err_strb;
    logic [AW:0]       word_count;
    logic              busy;

    fft_result_capture #(
        .WIDTH      (WIDTH),
        .ADDR_WIDTH (AW),
        .FRAME_LEN  (FL)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .s00_axis_tready (s00_axis_tready),
        .s00_axis_tdata  (s00_axis_tdata),
        .s00_axis_tstrb  (s00_axis_tstrb),
        .s00_axis_tlast  (s00_axis_tlast),
        .s00_axis_tvalid (s00_axis_tvalid),
        .arm             (arm),
        .rd_addr         (rd_addr),
        .rd_data         (rd_data),
        .frame_done      (frame_done),
        .err_short       (err_short),
        .err_long        (err_long),
        .err_strb        (err_strb),
        .word_count      (word_count),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Frame-level model: a frame is "open" from arm until its tlast word;
    // everything else follows from how many words arrived and where tlast was.
    // ------------------------------------------------------------------------
    logic [63:0] m_mem   [FL];
    bit          m_known [FL];
    bit          m_valid = 1'b0;
    bit          m_open  = 1'b0;
    bit          m_fin   = 1'b0;
    bit          m_strb  = 1'b0;
    int          m_n     = 0;
    int          m_last  = -1;
    logic [63:0] m_rd    = '0;
    bit          m_rd_known = 1'b0;

    always @(posedge clk) begin
        logic [63:0] old_val;
        bit          old_known;
        old_val   = m_mem[rd_addr];
        old_known = m_known[rd_addr];
        if (!rst) begin
            m_valid    = 1'b1;
            m_open     = 1'b0;
            m_fin      = 1'b0;
            m_strb     = 1'b0;
            m_n        = 0;
            m_last     = -1;
            m_rd       = '0;
            m_rd_known = 1'b1;
        end else begin
            m_rd       = old_val;
            m_rd_known = old_known;
            if (m_open) begin
                if (s00_axis_tvalid) begin
                    if (m_n < FL) begin
                        m_mem[m_n]   = s00_axis_tdata;
                        m_known[m_n] = 1'b1;
                        if (s00_axis_tstrb != 8'hff) m_strb = 1'b1;
                    end
                    if (s00_axis_tlast) begin
                        m_last = m_n;
                        m_open = 1'b0;
                        m_fin  = 1'b1;
                    end
                    m_n++;
                end
            end else if (arm) begin
                m_open = 1'b1;
                m_fin  = 1'b0;
                m_strb = 1'b0;
                m_n    = 0;
                m_last = -1;
            end
        end
    end

    // Cycle-by-cycle comparison of every output against the model
    always @(negedge clk) begin
        int wc;
        if (m_valid) begin
            wc = (m_n < FL) ? m_n : FL;
            chk("tready",     s00_axis_tready, m_open);
            chk("busy",       busy,            m_open);
            chk("frame_done", frame_done,      m_fin);
            chk("word_count", word_count,      wc);
            chk("err_short",  err_short,       m_fin && (m_n < FL));
            chk("err_long",   err_long,        (m_n >= FL) && (m_last != FL-1));
            chk("err_strb",   err_strb,        m_strb);
            if (m_rd_known) chk("rd_data", rd_data, m_rd);
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers (all entered and left on a falling edge)
    // ------------------------------------------------------------------------
    task automatic pulse_arm();
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
    endtask

    task automatic send_words(input int cnt, input int last_at, input bit rnd,
                              input int bad_at, input int arm_at, input logic [31:0] tag);
        int i   = 0;
        int cyc = 0;
        bit v;
        bit accept;
        while (i < cnt && cyc < 8000) begin
            v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            s00_axis_tvalid = v;
            s00_axis_tdata  = v ? {tag, 32'(i)} : {$urandom, $urandom};
            s00_axis_tstrb  = (i == bad_at) ? 8'h0f : 8'hff;
            s00_axis_tlast  = v && (i == last_at);
            arm             = (cyc == arm_at);
            accept          = v && s00_axis_tready;
            @(negedge clk);
            if (accept) i++;
            cyc++;
        end
        s00_axis_tvalid = 1'b0;
        s00_axis_tlast  = 1'b0;
        s00_axis_tstrb  = 8'hff;
        arm             = 1'b0;
        if (i < cnt) chk("stream_timeout", i, cnt);
    endtask

    task automatic read_lit(input string name, input int addr, input logic [63:0] exp);
        rd_addr = AW'(addr);
        @(negedge clk);
        chk(name, rd_data, exp);
    endtask

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    initial begin
        rst             = 1'b0;
        arm             = 1'b0;
        s00_axis_tvalid = 1'b0;
        s00_axis_tdata  = '0;
        s00_axis_tstrb  = 8'hff;
        s00_axis_tlast  = 1'b0;
        rd_addr         = '0;
        repeat (3) @(negedge clk);

        chk("reset_tready",     s00_axis_tready, 0);
        chk("reset_word_count", word_count,      0);
        chk("reset_rd_data",    rd_data,         0);
        chk("reset_busy",       busy,            0);
        rst = 1'b1;
        @(negedge clk);

        // Data offered before arm must be ignored
        s00_axis_tvalid = 1'b1;
        s00_axis_tdata  = 64'hdead_beef;
        repeat (20) @(negedge clk);
        s00_axis_tvalid = 1'b0;
        chk("prearm_tready",     s00_axis_tready, 0);
        chk("prearm_word_count", word_count,      0);

        // Nominal frame
        pulse_arm();
        send_words(1024, 1023, 1'b0, -1, -1, 32'd0);
        chk("nom_done",       frame_done, 1);
        chk("nom_word_count", word_count, 1024);
        chk("nom_err_short",  err_short,  0);
        chk("nom_err_long",   err_long,   0);
        chk("nom_err_strb",   err_strb,   0);
        read_lit("nom_rd5",    5,    64'd5);
        read_lit("nom_rd1023", 1023, 64'd1023);

        // Random tvalid bubbles; whole buffer swept against the model
        pulse_arm();
        send_words(1024, 1023, 1'b1, -1, -1, 32'd1);
        chk("bub_done", frame_done, 1);
        for (int a = 0; a < FL; a++) begin
            rd_addr = AW'(a);
            @(negedge clk);
        end
        read_lit("bub_rd300", 300, {32'd1, 32'd300});

        // Short frame
        pulse_arm();
        send_words(100, 99, 1'b0, -1, -1, 32'd2);
        chk("short_err",        err_short,       1);
        chk("short_done",       frame_done,      1);
        chk("short_word_count", word_count,      100);
        chk("short_tready",     s00_axis_tready, 0);
        read_lit("short_rd99",  99,  {32'd2, 32'd99});
        read_lit("short_rd100", 100, {32'd1, 32'd100});

        // Long frame
        pulse_arm();
        send_words(1030, 1029, 1'b0, -1, -1, 32'd3);
        chk("long_err",        err_long,        1);
        chk("long_word_count", word_count,      1024);
        chk("long_tready",     s00_axis_tready, 0);
        chk("long_done",       frame_done,      1);
        read_lit("long_rd1023", 1023, {32'd3, 32'd1023});
        read_lit("long_rd0",    0,    {32'd3, 32'd0});

        // Bad strobe on word 7, plus an arm pulse mid-capture
        pulse_arm();
        send_words(1024, 1023, 1'b0, 7, 50, 32'd4);
        chk("strb_err",        err_strb,   1);
        chk("strb_word_count", word_count, 1024);
        pulse_arm();
        chk("rearm_done",       frame_done,      0);
        chk("rearm_err_strb",   err_strb,        0);
        chk("rearm_err_long",   err_long,        0);
        chk("rearm_word_count", word_count,      0);
        chk("rearm_tready",     s00_axis_tready, 1);

        // Reset partway through a frame
        send_words(500, -1, 1'b0, -1, -1, 32'd5);
        chk("mid_word_count", word_count, 500);
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_tready",     s00_axis_tready, 0);
        chk("rstmid_word_count", word_count,      0);
        chk("rstmid_busy",       busy,            0);
        chk("rstmid_done",       frame_done,      0);
        rst = 1'b1;
        @(negedge clk);
        pulse_arm();
        send_words(1024, 1023, 1'b0, -1, -1, 32'd6);
        chk("post_done",       frame_done, 1);
        chk("post_word_count", word_count, 1024);
        read_lit("post_rd600", 600, {32'd6, 32'd600});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
